// File: rtl/reg_load_sequencer_if.sv
// Instruction handshake plus register-file / shift-register load bus of reg_load_sequencer.
// master = the sequencer (drives strobes), slave = instruction source and datapath side.
interface reg_load_sequencer_if #(
  parameter int INPUT_WIDTH = 4
);
  logic                   instr_valid;
  logic                   instr_ready;
  logic [3:0]             opcode;
  logic [INPUT_WIDTH-1:0] operand;
  logic [INPUT_WIDTH-1:0] data_a;
  logic [INPUT_WIDTH-1:0] data_b;
  logic                   LDA;
  logic                   LDB;
  logic                   LDO;
  logic                   shift_load;
  logic [3:0]             shift_in;
  logic [1:0]             shift_state;
  logic                   busy;
  logic                   done;
  logic                   illegal;

  modport master (
    input  instr_valid, opcode, operand,
    output instr_ready, data_a, data_b, LDA, LDB, LDO,
           shift_load, shift_in, shift_state, busy, done, illegal
  );

  modport slave (
    output instr_valid, opcode, operand,
    input  instr_ready, data_a, data_b, LDA, LDB, LDO,
           shift_load, shift_in, shift_state, busy, done, illegal
  );
endinterface

// File: rtl/reg_load_sequencer.sv
// Accepts one instruction per handshake and issues registered load/shift strobes with fixed timing.
// Define SEQ_SHIFT_EN to execute LSH/RSH/LSR; otherwise opcodes 4-6 retire as illegal.
module reg_load_sequencer #(
  parameter int INPUT_WIDTH = 4,
  parameter int ALU_LATENCY = 1,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_load_sequencer_if.master bus
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDA  = 4'd1;
  localparam logic [3:0] OP_LDB  = 4'd2;
  localparam logic [3:0] OP_EXEC = 4'd3;
`ifdef SEQ_SHIFT_EN
  localparam logic [3:0] OP_LSH  = 4'd4;
  localparam logic [3:0] OP_RSH  = 4'd5;
  localparam logic [3:0] OP_LSR  = 4'd6;
`endif

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] LAT_LAST = CNT_WIDTH'((ALU_LATENCY > 0) ? ALU_LATENCY - 1 : 0);
  localparam bit                   LAT_ZERO = (ALU_LATENCY == 0);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_EXEC_WAIT = 3'd2,
    S_WRITE     = 3'd3,
    S_DONE      = 3'd4
`ifdef SEQ_SHIFT_EN
    , S_SHIFT   = 3'd5
`endif
  } state_t;

  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_ready;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_illegal;
  logic                   r_lda;
  logic                   r_ldb;
  logic                   r_ldo;
  logic [INPUT_WIDTH-1:0] r_data_a;
  logic [INPUT_WIDTH-1:0] r_data_b;
`ifdef SEQ_SHIFT_EN
  logic                   r_shift_load;
  logic [1:0]             r_shift_state;
  logic [3:0]             r_shift_in;
`endif

  // Every output is computed for the state being entered, so it is a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_ready       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_illegal     <= 1'b0;
      r_lda         <= 1'b0;
      r_ldb         <= 1'b0;
      r_ldo         <= 1'b0;
      r_data_a      <= '0;
      r_data_b      <= '0;
`ifdef SEQ_SHIFT_EN
      r_shift_load  <= 1'b0;
      r_shift_state <= 2'b00;
      r_shift_in    <= 4'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (r_ready && bus.instr_valid) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            case (bus.opcode)
              OP_NOP: begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
              OP_LDA: begin
                r_data_a <= bus.operand;
                r_lda    <= 1'b1;
                r_state  <= S_LOAD;
              end
              OP_LDB: begin
                r_data_b <= bus.operand;
                r_ldb    <= 1'b1;
                r_state  <= S_LOAD;
              end
              OP_EXEC: begin
                if (LAT_ZERO) begin
                  r_ldo   <= 1'b1;
                  r_state <= S_WRITE;
                end else begin
                  r_cnt   <= LAT_LAST;
                  r_state <= S_EXEC_WAIT;
                end
              end
`ifdef SEQ_SHIFT_EN
              OP_LSR: begin
                r_shift_in   <= 4'(bus.operand);
                r_shift_load <= 1'b1;
                r_state      <= S_LOAD;
              end
              OP_LSH, OP_RSH: begin
                if (bus.operand == '0) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
                end else begin
                  // Counter holds remaining shift cycles minus one.
                  r_cnt         <= CNT_WIDTH'(bus.operand - INPUT_WIDTH'(1));
                  r_shift_state <= (bus.opcode == OP_LSH) ? 2'b10 : 2'b01;
                  r_state       <= S_SHIFT;
                end
              end
`endif
              default: begin
                r_done    <= 1'b1;
                r_illegal <= 1'b1;
                r_state   <= S_DONE;
              end
            endcase
          end
        end

        S_LOAD: begin
          r_lda        <= 1'b0;
          r_ldb        <= 1'b0;
`ifdef SEQ_SHIFT_EN
          r_shift_load <= 1'b0;
`endif
          r_done       <= 1'b1;
          r_state      <= S_DONE;
        end

        S_EXEC_WAIT: begin
          if (r_cnt == '0) begin
            r_ldo   <= 1'b1;
            r_state <= S_WRITE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        S_WRITE: begin
          r_ldo   <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end

`ifdef SEQ_SHIFT_EN
        S_SHIFT: begin
          if (r_cnt == '0) begin
            r_shift_state <= 2'b00;
            r_done        <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
`endif

        S_DONE: begin
          r_done    <= 1'b0;
          r_illegal <= 1'b0;
          r_busy    <= 1'b0;
          r_ready   <= 1'b1;
          r_state   <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready = r_ready;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.illegal     = r_illegal;
  assign bus.LDA         = r_lda;
  assign bus.LDB         = r_ldb;
  assign bus.LDO         = r_ldo;
  assign bus.data_a      = r_data_a;
  assign bus.data_b      = r_data_b;
`ifdef SEQ_SHIFT_EN
  assign bus.shift_load  = r_shift_load;
  assign bus.shift_state = r_shift_state;
  assign bus.shift_in    = r_shift_in;
`else
  assign bus.shift_load  = 1'b0;
  assign bus.shift_state = 2'b00;
  assign bus.shift_in    = 4'd0;
`endif

endmodule

// File: tb/tb_reg_load_sequencer.sv
// Directed + randomized bench for reg_load_sequencer; expected waveforms come from a per-opcode
// plan (strobe count, strobe kind, illegal flag) rather than from any state machine.
module tb_reg_load_sequencer;
  localparam int W   = 4;
  localparam int LAT = 3;
  localparam int CW  = 4;
`ifdef SEQ_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  localparam int K_NONE  = 0;
  localparam int K_LDA   = 1;
  localparam int K_LDB   = 2;
  localparam int K_LDO   = 3;
  localparam int K_SLOAD = 4;
  localparam int K_LSH   = 5;
  localparam int K_RSH   = 6;

  typedef struct {
    int n;
    int kind;
    bit ill;
  } plan_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  reg_load_sequencer_if #(.INPUT_WIDTH(W)) bus ();

  reg_load_sequencer #(
    .INPUT_WIDTH(W),
    .ALU_LATENCY(LAT),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk  (clk),
    .reset(reset_n),
    .bus  (bus.master)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] m_a   = '0;
  logic [W-1:0] m_b   = '0;
  logic [3:0]   m_sin = 4'd0;

  function automatic logic [21:0] pack_obs();
    return {bus.instr_ready, bus.busy, bus.done, bus.illegal,
            bus.LDA, bus.LDB, bus.LDO, bus.shift_load,
            bus.shift_state, bus.shift_in, bus.data_a, bus.data_b};
  endfunction

  function automatic logic [21:0] idle_word();
    return {1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'b00, m_sin, m_a, m_b};
  endfunction

  // Busy cycles 1..n carry the strobe (LDO only on the last one), cycle n+1 is the done pulse.
  function automatic logic [21:0] busy_word(input plan_t p, input int k);
    logic on, dn;
    logic [1:0] ss;
    on = (k <= p.n) && (p.kind != K_LDO || k == p.n);
    dn = (k == p.n + 1);
    ss = (on && p.kind == K_LSH) ? 2'b10 : (on && p.kind == K_RSH) ? 2'b01 : 2'b00;
    return {1'b0, 1'b1, dn, dn && p.ill,
            on && p.kind == K_LDA, on && p.kind == K_LDB, on && p.kind == K_LDO,
            on && p.kind == K_SLOAD, ss, m_sin, m_a, m_b};
  endfunction

  function automatic plan_t plan(input logic [3:0] op, input logic [W-1:0] opd);
    plan_t p;
    p.n = 0; p.kind = K_NONE; p.ill = 1'b0;
    case (op)
      4'd0: ;
      4'd1: begin p.n = 1; p.kind = K_LDA; end
      4'd2: begin p.n = 1; p.kind = K_LDB; end
      4'd3: begin p.n = LAT + 1; p.kind = K_LDO; end
      4'd4: if (SHIFT_EN) begin p.n = int'(opd); p.kind = K_LSH; end else p.ill = 1'b1;
      4'd5: if (SHIFT_EN) begin p.n = int'(opd); p.kind = K_RSH; end else p.ill = 1'b1;
      4'd6: if (SHIFT_EN) begin p.n = 1; p.kind = K_SLOAD; end else p.ill = 1'b1;
      default: p.ill = 1'b1;
    endcase
    return p;
  endfunction

  task automatic check(input string tag, input logic [21:0] obs, input logic [21:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int guard = 0;
    while (bus.instr_ready !== 1'b1 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    check({name, " ready"}, pack_obs(), idle_word());
  endtask

  task automatic accept(input logic [3:0] op, input logic [W-1:0] opd);
    bus.instr_valid = 1'b1;
    bus.opcode      = op;
    bus.operand     = opd;
    @(posedge clk); #1;
    if (op == 4'd1) m_a = opd;
    if (op == 4'd2) m_b = opd;
    if (op == 4'd6 && SHIFT_EN) m_sin = 4'(opd);
  endtask

  // Inputs are scrambled every busy cycle to show that they are ignored until the next accept.
  task automatic run_instr(input logic [3:0] op, input logic [W-1:0] opd, input string name);
    plan_t p;
    wait_ready(name);
    p = plan(op, opd);
    accept(op, opd);
    for (int k = 1; k <= p.n + 1; k++) begin
      bus.instr_valid = (k == p.n + 1) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.opcode      = 4'($urandom);
      bus.operand     = W'($urandom);
      check($sformatf("%s op=%0d opd=%0d c%0d", name, op, opd, k), pack_obs(), busy_word(p, k));
      @(posedge clk); #1;
    end
    check({name, " idle"}, pack_obs(), idle_word());
    $display("txn %-8s op=%0d opd=%0h strobe_cycles=%0d illegal=%0b", name, op, opd, p.n, p.ill);
  endtask

  initial begin
    plan_t p;
    logic [3:0]   rop;
    logic [W-1:0] ropd;

    bus.instr_valid = 1'b1;
    bus.opcode      = 4'd1;
    bus.operand     = 4'h5;
    reset_n         = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("reset c%0d", i), pack_obs(), 22'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    check("reset release", pack_obs(), idle_word());

    run_instr(4'd1, 4'hA, "LDA");
    run_instr(4'd2, 4'h3, "LDB");
    run_instr(4'd3, 4'h0, "EXEC");
    run_instr(4'd5, 4'h5, "RSH5");
    run_instr(4'd5, 4'h0, "RSH0");
    run_instr(4'd4, 4'h2, "LSH2");
    run_instr(4'd6, 4'h9, "LSR");
    run_instr(4'hF, 4'h7, "ILLF");
    run_instr(4'd4, 4'h1, "OP4");
    run_instr(4'd0, 4'hC, "NOP");
    run_instr(4'd7, 4'h0, "ILL7");
    run_instr(4'd1, 4'h0, "LDA0");

    // Abort a long instruction three cycles in with an asynchronous reset.
    rop  = SHIFT_EN ? 4'd4 : 4'd3;
    ropd = 4'h7;
    wait_ready("abort");
    p = plan(rop, ropd);
    accept(rop, ropd);
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort c3", pack_obs(), busy_word(p, 3));
    #2 reset_n = 1'b0;
    #1 check("abort immediate", pack_obs(), 22'd0);
    m_a = '0; m_b = '0; m_sin = 4'd0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("abort after c%0d", i), pack_obs(), idle_word());
    end
    $display("txn %-8s op=%0d opd=%0h aborted by reset", "abort", rop, ropd);

    for (int t = 0; t < 40; t++) begin
      rop  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      ropd = W'($urandom);
      run_instr(rop, ropd, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
